line_tap_buffer: RTL and testbench

LINE_TAP_BUFFER -- requirements
Module: line_tap_buffer

---
 rtl/isp_pkg.sv | 15 +
 rtl/line_ram.sv | 32 +++
 rtl/line_tap_buffer.sv | 105 ++++++++++
 tb/tb_line_tap_buffer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP definitions: column/fill widths and the stored-line upper bound.
package isp_pkg;

    localparam int COL_W     = 12;
    localparam int MAX_LINES = 4;
    localparam int FILL_W    = $clog2(MAX_LINES + 1);

    typedef logic [COL_W-1:0]  col_t;
    typedef logic [FILL_W-1:0] fill_t;

    function automatic fill_t sat_inc(input fill_t v, input fill_t lim);
        return (v == lim) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store with registered read; a read colliding with a
// write returns the previous content. Storage itself is never reset.
module line_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 1,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/line_tap_buffer.sv
// Vertical tap generator: cascades LINES line stores so each output carries the
// current pixel plus the pixels 1..LINES lines above in the same column.
module line_tap_buffer
    import isp_pkg::*;
#(
    parameter int DATA_W         = 1,
    parameter int IMG_WIDTH_LINE = 1024,
    parameter int LINES          = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_sof,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    output logic [(LINES+1)*DATA_W-1:0]  out_taps,
    output logic [COL_W-1:0]             out_col,
    output logic                         out_lines_ok
);

    localparam int    AW       = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
    localparam col_t  LAST_COL = col_t'(IMG_WIDTH_LINE - 1);
    localparam fill_t FULL     = fill_t'(LINES);

    col_t              col;
    col_t              eff_col;
    fill_t             fill;
    fill_t             eff_fill;
    logic              accept;
    logic              collide;
    logic              wr_en_q;
    logic [AW-1:0]     wr_addr_q;
    logic [DATA_W-1:0] data_q;
    logic              byp_q;
    logic [DATA_W-1:0] fwd_q   [LINES];
    logic [DATA_W-1:0] rd_data [LINES];
    logic [DATA_W-1:0] tap     [LINES+1];

    assign accept   = in_valid && !rst;
    assign eff_col  = in_sof ? '0 : col;
    assign eff_fill = in_sof ? '0 : fill;
    // RAM writes land one cycle late; a read of that same address must see the
    // value in flight rather than the stale array content.
    assign collide  = wr_en_q && (wr_addr_q == eff_col[AW-1:0]);
    assign tap[0]   = data_q;

    for (genvar k = 0; k < LINES; k++) begin : g_line
        assign tap[k+1] = byp_q ? fwd_q[k] : rd_data[k];

        line_ram #(
            .DEPTH (IMG_WIDTH_LINE),
            .DATA_W(DATA_W),
            .AW    (AW)
        ) u_line_ram (
            .clk    (clk),
            .rst    (rst),
            .rd_en  (accept),
            .rd_addr(eff_col[AW-1:0]),
            .rd_data(rd_data[k]),
            .wr_en  (wr_en_q),
            .wr_addr(wr_addr_q),
            .wr_data(tap[k])
        );
    end

    for (genvar k = 0; k <= LINES; k++) begin : g_taps
        assign out_taps[k*DATA_W +: DATA_W] = tap[k];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col          <= '0;
            fill         <= '0;
            out_valid    <= 1'b0;
            out_col      <= '0;
            out_lines_ok <= 1'b0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            byp_q        <= 1'b0;
            for (int k = 0; k < LINES; k++)
                fwd_q[k] <= '0;
        end else begin
            out_valid <= in_valid;
            wr_en_q   <= in_valid;
            if (in_valid) begin
                data_q       <= in_data;
                out_col      <= eff_col;
                out_lines_ok <= (eff_fill == FULL);
                wr_addr_q    <= eff_col[AW-1:0];
                byp_q        <= collide;
                for (int k = 0; k < LINES; k++)
                    fwd_q[k] <= tap[k];
                if (eff_col == LAST_COL) begin
                    col  <= '0;
                    fill <= sat_inc(eff_fill, FULL);
                end else begin
                    col  <= eff_col + 1'b1;
                    fill <= eff_fill;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_tap_buffer.sv
// Directed bench: small 4-wide 8-bit instance for fill/gap/sof/reset cases and
// a default-parameter instance for a full 1024-wide three-line pattern.
module tb_line_tap_buffer;
    import isp_pkg::*;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    logic             a_rst, a_sof, a_valid;
    logic [7:0]       a_data;
    logic             a_ovalid, a_ok;
    logic [23:0]      a_taps;
    logic [COL_W-1:0] a_col;

    line_tap_buffer #(.DATA_W(8), .IMG_WIDTH_LINE(4), .LINES(2)) u_dut_a (
        .clk(clk), .rst(a_rst), .in_sof(a_sof), .in_valid(a_valid), .in_data(a_data),
        .out_valid(a_ovalid), .out_taps(a_taps), .out_col(a_col), .out_lines_ok(a_ok)
    );

    logic             b_rst, b_sof, b_valid;
    logic [0:0]       b_data;
    logic             b_ovalid, b_ok;
    logic [2:0]       b_taps;
    logic [COL_W-1:0] b_col;

    line_tap_buffer u_dut_b (
        .clk(clk), .rst(b_rst), .in_sof(b_sof), .in_valid(b_valid), .in_data(b_data),
        .out_valid(b_ovalid), .out_taps(b_taps), .out_col(b_col), .out_lines_ok(b_ok)
    );

    task automatic a_px(input logic r, input logic s, input logic v, input logic [7:0] d);
        a_rst = r; a_sof = s; a_valid = v; a_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic b_px(input logic s, input logic v, input logic d);
        b_sof = s; b_valid = v; b_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst = 1; a_sof = 0; a_valid = 0; a_data = 0;
        b_rst = 1; b_sof = 0; b_valid = 0; b_data = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", a_ovalid, 0);
        chk("rst_taps", a_taps, 0);
        chk("rst_col", a_col, 0);
        chk("rst_ok", a_ok, 0);
        chk("rst_b_taps", b_taps, 0);
        a_rst = 0; b_rst = 0;

        // fill: pixel i carries value i
        for (int i = 0; i < 12; i++) begin
            a_px(0, i == 0, 1, 8'(i));
            chk($sformatf("fill_valid[%0d]", i), a_ovalid, 1);
            chk($sformatf("fill_col[%0d]", i), a_col, i % 4);
            chk($sformatf("fill_ok[%0d]", i), a_ok, i >= 8);
            if (i >= 8)
                chk($sformatf("fill_taps[%0d]", i), a_taps, {8'(i - 8), 8'(i - 4), 8'(i)});
        end

        // same stream with idle cycles between pixels
        for (int i = 0; i < 12; i++) begin
            a_px(0, i == 0, 1, 8'(i));
            chk($sformatf("gap_valid[%0d]", i), a_ovalid, 1);
            chk($sformatf("gap_col[%0d]", i), a_col, i % 4);
            chk($sformatf("gap_ok[%0d]", i), a_ok, i >= 8);
            if (i >= 8)
                chk($sformatf("gap_taps[%0d]", i), a_taps, {8'(i - 8), 8'(i - 4), 8'(i)});
            a_px(0, 0, 0, 8'hee);
            chk($sformatf("gap_idle_valid[%0d]", i), a_ovalid, 0);
            chk($sformatf("gap_idle_col[%0d]", i), a_col, i % 4);
            if (i >= 8)
                chk($sformatf("gap_idle_taps[%0d]", i), a_taps, {8'(i - 8), 8'(i - 4), 8'(i)});
        end

        // sof arriving at col 2 restarts the frame
        for (int i = 0; i < 6; i++)
            a_px(0, i == 0, 1, 8'(20 + i));
        for (int j = 0; j < 10; j++) begin
            a_px(0, j == 0, 1, 8'(50 + j));
            chk($sformatf("mid_col[%0d]", j), a_col, j % 4);
            chk($sformatf("mid_ok[%0d]", j), a_ok, j >= 8);
            if (j >= 8)
                chk($sformatf("mid_taps[%0d]", j), a_taps, {8'(42 + j), 8'(46 + j), 8'(50 + j)});
        end

        // back-to-back sof pixels hit the same address
        a_px(0, 1, 1, 8'd200);
        a_px(0, 1, 1, 8'd201);
        chk("coll_tap1", a_taps[15:8], 200);
        chk("coll_col", a_col, 0);
        a_px(0, 0, 1, 8'd202);
        chk("coll_next_taps", a_taps, {8'd55, 8'd59, 8'd202});
        chk("coll_next_col", a_col, 1);

        // reset together with a valid pixel
        for (int i = 0; i < 5; i++)
            a_px(0, i == 0, 1, 8'(70 + i));
        a_px(1, 0, 1, 8'd75);
        chk("rstmid_valid", a_ovalid, 0);
        chk("rstmid_taps", a_taps, 0);
        chk("rstmid_col", a_col, 0);
        chk("rstmid_ok", a_ok, 0);
        a_px(0, 0, 1, 8'd76);
        chk("rstmid_next_valid", a_ovalid, 1);
        chk("rstmid_next_col", a_col, 0);
        chk("rstmid_next_ok", a_ok, 0);
        chk("rstmid_next_tap0", a_taps[7:0], 76);
        a_px(0, 0, 1, 8'd77);
        chk("rstmid_next2_col", a_col, 1);
        a_px(0, 0, 0, 8'd0);

        // default instance: pixel (line l, col c) = c[0] ^ l[0]
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 1024; c++) begin
                b_px(l == 0 && c == 0, 1, 1'(c ^ l));
                if (c == 1023)
                    chk($sformatf("b_last_col[%0d]", l), b_col, 1023);
                if (c == 0 && l > 0)
                    chk($sformatf("b_wrap_col[%0d]", l), b_col, 0);
                if (l == 2) begin
                    chk($sformatf("b_taps[%0d]", c), b_taps, {1'(c), 1'(c ^ 1), 1'(c)});
                    if (c == 0 || c == 1023)
                        chk($sformatf("b_ok[%0d]", c), b_ok, 1);
                end
                if (l == 1 && c == 1023)
                    chk("b_ok_line1", b_ok, 0);
            end
        end
        b_px(0, 0, 0);
        chk("b_idle_valid", b_ovalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
